// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
// Bundles the load/status/display signals of the seven-segment scan driver.
//   bin_in   [13:0]  binary reading to convert (master -> slave)
//   load             single-cycle convert request (master -> slave)
//   blank_lz         1 = blank leading zeros (master -> slave)
//   busy             conversion in progress (slave -> master)
//   bcd_out  [3:0]   BCD code of the selected digit (slave -> master)
//   anode    [3:0]   active-low digit enables, bit 0 = ones (slave -> master)
// -----------------------------------------------------------------------------
interface seg_scan_driver_if;
   logic [13:0] bin_in;
   logic        load;
   logic        blank_lz;
   logic        busy;
   logic [3:0]  bcd_out;
   logic [3:0]  anode;

   modport master (
      output bin_in, load, blank_lz,
      input  busy, bcd_out, anode
   );

   modport slave (
      input  bin_in, load, blank_lz,
      output busy, bcd_out, anode
   );
endinterface

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Converts a 14-bit binary reading to four BCD digits with an iterative
// double-dabble engine, holds the result in display registers and
// time-multiplexes the digits onto a shared BCD bus with active-low anodes.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   bus      seg_scan_driver_if.slave (bin_in, load, blank_lz, busy,
//            bcd_out, anode)
// Parameter:
//   REFRESH_DIV  cycles each digit stays lit (>= 2)
// -----------------------------------------------------------------------------
module seg_scan_driver #(
   parameter int REFRESH_DIV = 50000
) (
   input logic             clk,
   input logic             rst,
   seg_scan_driver_if.slave bus
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [13:0]      r_shift;
   logic [13:0]      w_shift_nxt;
   logic [15:0]      r_acc;
   logic [15:0]      w_acc_nxt;
   logic [3:0]       r_iter;
   logic [3:0]       w_iter_nxt;
   logic             r_ovf;
   logic             w_ovf_nxt;
   logic [15:0]      r_disp;
   logic [15:0]      w_disp_nxt;
   logic [29:0]      w_cat;
   logic [CNT_W-1:0] r_refresh_cnt;
   logic [1:0]       r_idx;
   logic [3:0]       w_digit;
   logic             w_blank;
   logic [3:0]       w_anode;

   // Double-dabble correction: every BCD nibble >= 5 gets 3 added before the shift.
   function automatic logic [15:0] f_add3(input logic [15:0] i_acc);
      logic [15:0] v;
      v = i_acc;
      for (int k = 0; k < 4; k++) begin
         v[4*k +: 4] = (v[4*k +: 4] >= 4'd5) ? (v[4*k +: 4] + 4'd3) : v[4*k +: 4];
      end
      return v;
   endfunction

   // Converter state and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_shift <= 14'd0;
         r_acc   <= 16'd0;
         r_iter  <= 4'd0;
         r_ovf   <= 1'b0;
         r_disp  <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_acc   <= w_acc_nxt;
         r_iter  <= w_iter_nxt;
         r_ovf   <= w_ovf_nxt;
         r_disp  <= w_disp_nxt;
      end
   end

   // Converter next-state and datapath logic.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_acc_nxt   = r_acc;
      w_iter_nxt  = r_iter;
      w_ovf_nxt   = r_ovf;
      w_disp_nxt  = r_disp;
      // {corrected accumulator, shift register} moved left by one bit;
      // the accumulator's top bit falls off (only matters on overflow).
      w_cat       = {f_add3(r_acc), r_shift} << 1;

      case (r_state)
         ST_IDLE: begin
            if (bus.load) begin
               w_shift_nxt = bus.bin_in;
               w_acc_nxt   = 16'd0;
               w_iter_nxt  = 4'd0;
               // Overflow is judged on the captured value, not on later bin_in.
               w_ovf_nxt   = (bus.bin_in > 14'd9999);
               w_state_nxt = ST_SHIFT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            w_acc_nxt   = w_cat[29:14];
            w_shift_nxt = w_cat[13:0];
            w_iter_nxt  = r_iter + 4'd1;
            if (r_iter == 4'd13) begin
               w_state_nxt = ST_LATCH;
            end else begin
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_LATCH: begin
            w_disp_nxt  = r_ovf ? 16'hEEEE : r_acc;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Refresh counter and digit index; free-running, never stalled by the converter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_refresh_cnt <= {CNT_W{1'b0}};
         r_idx         <= 2'd0;
      end else if (r_refresh_cnt == CNT_LAST) begin
         r_refresh_cnt <= {CNT_W{1'b0}};
         r_idx         <= r_idx + 2'd1;
      end else begin
         r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
      end
   end

   // Digit select, leading-zero blanking and anode decode.
   always_comb begin
      w_digit = r_disp[{r_idx, 2'b00} +: 4];
      // A digit is blanked when it and every higher digit are zero; an
      // overflow pattern (all E) can never satisfy that, so it is never blanked.
      case (r_idx)
         2'd0:    w_blank = 1'b0;
         2'd1:    w_blank = (r_disp[15:4] == 12'd0);
         2'd2:    w_blank = (r_disp[15:8] == 8'd0);
         2'd3:    w_blank = (r_disp[15:12] == 4'd0);
         default: w_blank = 1'b0;
      endcase
      case (r_idx)
         2'd0:    w_anode = 4'b1110;
         2'd1:    w_anode = 4'b1101;
         2'd2:    w_anode = 4'b1011;
         2'd3:    w_anode = 4'b0111;
         default: w_anode = 4'b1111;
      endcase
      if (bus.blank_lz && w_blank) begin
         w_anode = 4'b1111;
      end else begin
         w_anode = w_anode;
      end
   end

   assign bus.busy    = (r_state != ST_IDLE);
   assign bus.bcd_out = w_digit;
   assign bus.anode   = w_anode;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Self-checking bench for seg_scan_driver with REFRESH_DIV = 4. A behavioural
// model tracks elapsed cycles, pending conversions and the displayed value as
// plain integers; expected digits come from decimal division.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

   localparam int RDIV = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   seg_scan_driver_if bus ();

   seg_scan_driver #(.REFRESH_DIV(RDIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model state: cycles since reset, shown value, pending conversion.
   int m_tick;
   int m_disp;
   int m_pending;
   int m_left;

   // Reference model: a load accepted when idle shows its value 15 edges later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_tick    <= 0;
         m_disp    <= 0;
         m_pending <= 0;
         m_left    <= 0;
      end else begin
         m_tick <= m_tick + 1;
         if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_disp <= m_pending;
         end else if (bus.load) begin
            m_pending <= int'(bus.bin_in);
            m_left    <= 15;
         end
      end
   end

   function automatic int cur_idx();
      return (m_tick / RDIV) % 4;
   endfunction

   function automatic int pow10(int k);
      return (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
   endfunction

   function automatic logic [3:0] exp_bcd();
      if (m_disp > 9999) return 4'hE;
      return 4'((m_disp / pow10(cur_idx())) % 10);
   endfunction

   function automatic logic [3:0] exp_anode();
      logic [3:0] a;
      int idx;
      idx = cur_idx();
      a = 4'b1111;
      if (m_disp <= 9999 && bus.blank_lz && idx > 0 && (m_disp / pow10(idx)) == 0) return a;
      a[idx] = 1'b0;
      return a;
   endfunction

   function automatic logic exp_busy();
      return (m_left > 0);
   endfunction

   task automatic test_reset();
      bus.load     = 1'b0;
      bus.bin_in   = 14'd0;
      bus.blank_lz = 1'b0;
      rst          = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if (bus.anode !== 4'b1110 || bus.bcd_out !== 4'h0 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: anode=%b bcd=%h busy=%b expected anode=1110 bcd=0 busy=0",
                  bus.anode, bus.bcd_out, bus.busy);
      end
      rst = 1'b0;
      for (int c = 0; c < 4 * RDIV + 2; c++) begin
         @(negedge clk);
         n_vec++;
         if (bus.anode !== exp_anode() || bus.bcd_out !== 4'h0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_scan c=%0d: anode=%b bcd=%h busy=%b expected anode=%b bcd=0 busy=0",
                     c, bus.anode, bus.bcd_out, bus.busy, exp_anode());
         end
      end
   endtask

   task automatic test_load_1234();
      int nb;
      nb = 0;
      bus.blank_lz = 1'b0;
      bus.bin_in   = 14'd1234;
      bus.load     = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         bus.load   = 1'b0;
         bus.bin_in = 14'($urandom);
         if (bus.busy === 1'b1) nb++;
         n_vec++;
         if (bus.anode !== exp_anode() || bus.bcd_out !== exp_bcd() || bus.busy !== exp_busy()) begin
            n_err++;
            $display("FAIL load_1234 c=%0d: anode=%b bcd=%h busy=%b expected anode=%b bcd=%h busy=%b",
                     c, bus.anode, bus.bcd_out, bus.busy, exp_anode(), exp_bcd(), exp_busy());
         end
      end
      n_vec++;
      if (nb != 15) begin
         n_err++;
         $display("FAIL busy_length: busy cycles=%0d expected 15", nb);
      end
   endtask

   task automatic test_values(string name, int val, logic blz);
      bus.blank_lz = blz;
      bus.bin_in   = 14'(val);
      bus.load     = 1'b1;
      for (int c = 0; c < 15 + 4 * RDIV + 4; c++) begin
         @(negedge clk);
         bus.load   = 1'b0;
         bus.bin_in = 14'($urandom);
         n_vec++;
         if (bus.anode !== exp_anode() || bus.bcd_out !== exp_bcd() || bus.busy !== exp_busy()) begin
            n_err++;
            $display("FAIL %s val=%0d c=%0d: anode=%b bcd=%h busy=%b expected anode=%b bcd=%h busy=%b",
                     name, val, c, bus.anode, bus.bcd_out, bus.busy, exp_anode(), exp_bcd(), exp_busy());
         end
      end
   endtask

   task automatic test_ignored_load();
      bus.blank_lz = 1'b1;
      bus.bin_in   = 14'd2468;
      bus.load     = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);   // just after edge E<c>
         n_vec++;
         if (bus.anode !== exp_anode() || bus.bcd_out !== exp_bcd() || bus.busy !== exp_busy()) begin
            n_err++;
            $display("FAIL ignored_load c=%0d: anode=%b bcd=%h busy=%b expected anode=%b bcd=%h busy=%b",
                     c, bus.anode, bus.bcd_out, bus.busy, exp_anode(), exp_bcd(), exp_busy());
         end
         if (c == 14 || c == 15) begin
            n_vec++;
            if (bus.busy !== (c == 14)) begin
               n_err++;
               $display("FAIL busy_drop c=%0d: busy=%b expected %b", c, bus.busy, (c == 14));
            end
         end
         bus.load   = (c == 4);   // second request lands on E5
         bus.bin_in = (c == 4) ? 14'd1357 : 14'($urandom);
      end
   endtask

   task automatic test_reset_mid();
      test_values("pre_reset_1234", 1234, 1'b0);
      bus.bin_in = 14'd5678;
      bus.load   = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         bus.load = 1'b0;
      end
      @(posedge clk);   // E7
      #1 rst = 1'b1;
      #1;
      n_vec++;
      if (bus.busy !== 1'b0 || bus.bcd_out !== 4'h0 || bus.anode !== 4'b1110) begin
         n_err++;
         $display("FAIL reset_mid: anode=%b bcd=%h busy=%b expected anode=1110 bcd=0 busy=0",
                  bus.anode, bus.bcd_out, bus.busy);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4 * RDIV; c++) begin
         @(negedge clk);
         n_vec++;
         if (bus.anode !== exp_anode() || bus.bcd_out !== 4'h0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset c=%0d: anode=%b bcd=%h busy=%b expected anode=%b bcd=0 busy=0",
                     c, bus.anode, bus.bcd_out, bus.busy, exp_anode());
         end
      end
      test_values("after_reset_42", 42, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         n_vec++;
         if (bus.anode !== exp_anode() || bus.bcd_out !== exp_bcd() || bus.busy !== exp_busy()) begin
            n_err++;
            $display("FAIL back_to_back c=%0d: anode=%b bcd=%h busy=%b expected anode=%b bcd=%h busy=%b",
                     c, bus.anode, bus.bcd_out, bus.busy, exp_anode(), exp_bcd(), exp_busy());
         end
         bus.load = ($urandom_range(0, 3) == 0);
         bus.bin_in = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(10000, 16383))
                                                  : 14'($urandom_range(0, 9999));
         if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
      end
      bus.load = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      bus.load     = 1'b0;
      bus.bin_in   = 14'd0;
      bus.blank_lz = 1'b0;
      test_reset();
      test_load_1234();
      test_values("max_9999", 9999, 1'b0);
      test_values("ovf_10000", 10000, 1'b1);
      test_values("ovf_16383", 16383, 1'b1);
      test_values("blank_7", 7, 1'b1);
      test_values("blank_0", 0, 1'b1);
      test_values("blank_40", 40, 1'b1);
      test_values("blank_305", 305, 1'b1);
      test_values("blank_1000", 1000, 1'b1);
      test_ignored_load();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
